// File: rtl/dsp_mac_sequencer_if.sv
// Handshake and slice-control bundle between an operand source and the
// DSP48A1 MAC sequencer.
interface dsp_mac_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] n_samples;
   logic             in_valid;
   logic             in_ready;
   logic             CE_PIPE;
   logic [7:0]       OPMODE;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output n_samples,
      output in_valid,
      input  in_ready,
      input  CE_PIPE,
      input  OPMODE,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  n_samples,
      input  in_valid,
      output in_ready,
      output CE_PIPE,
      output OPMODE,
      output busy,
      output done
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice (AREG/BREG, MREG, PREG on, OPMODE unregistered)
// as an N-sample multiply-accumulator, P = sum(A*B).
module dsp_mac_sequencer #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TAG_DLY = 2
) (
   input  logic                CLK,
   input  logic                RST_N,
   dsp_mac_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      TAG_BUBBLE = 2'd0,
      TAG_FIRST  = 2'd1,
      TAG_ACC    = 2'd2
   } tag_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] drain_q, drain_d;
   logic             first_q, first_d;
   tag_t             tag_q [TAG_DLY];
   tag_t             tag_d [TAG_DLY];

   logic             in_ready_c;
   logic             ce_c;
   logic             done_c;
   tag_t             push_tag;
   logic [7:0]       opmode_c;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         drain_q     <= '0;
         first_q     <= 1'b0;
         for (int unsigned i = 0; i < TAG_DLY; i++) begin
            tag_q[i] <= TAG_BUBBLE;
         end
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         drain_q     <= drain_d;
         first_q     <= first_d;
         for (int unsigned i = 0; i < TAG_DLY; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      drain_d     = drain_q;
      first_d     = first_q;
      in_ready_c  = 1'b0;
      ce_c        = 1'b0;
      done_c      = 1'b0;
      push_tag    = TAG_BUBBLE;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               remaining_d = bus.n_samples;
               first_d     = 1'b1;
               state_d     = (bus.n_samples == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               ce_c     = 1'b1;
               push_tag = first_q ? TAG_FIRST : TAG_ACC;
               first_d  = 1'b0;
               if (remaining_q != '0) begin
                  remaining_d = remaining_q - 1'b1;
               end
               if (remaining_q == CNT_W'(1)) begin
                  drain_d = CNT_W'(TAG_DLY);
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Clock bubbles through so the last products reach P.
            ce_c     = 1'b1;
            push_tag = TAG_BUBBLE;
            if (drain_q != '0) begin
               drain_d = drain_q - 1'b1;
            end
            if (drain_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_c  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Tags move only with CE_PIPE so they stay aligned with the frozen slice.
   always_comb begin
      for (int unsigned i = 0; i < TAG_DLY; i++) begin
         tag_d[i] = tag_q[i];
      end
      if (ce_c) begin
         tag_d[0] = push_tag;
         for (int unsigned i = 1; i < TAG_DLY; i++) begin
            tag_d[i] = tag_q[i-1];
         end
      end
   end

   always_comb begin
      opmode_c = 8'h08;
      unique case (tag_q[TAG_DLY-1])
         TAG_FIRST:  opmode_c = 8'h01;
         TAG_ACC:    opmode_c = 8'h09;
         default:    opmode_c = 8'h08;
      endcase
   end

   assign bus.in_ready = in_ready_c;
   assign bus.CE_PIPE  = ce_c;
   assign bus.OPMODE   = opmode_c;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_c;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice
// (A/B reg, M reg, P reg, shared CE) with directed sample sets.
module tb_dsp_mac_sequencer;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned TAG_DLY = 2;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   always #5 CLK = ~CLK;

   dsp_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

   dsp_mac_sequencer #(
      .CNT_W   (CNT_W),
      .TAG_DLY (TAG_DLY)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   // Behavioural slice: two register stages ahead of the post-adder.
   logic [17:0] a_in = '0, b_in = '0;
   logic [17:0] a_r = '0, b_r = '0;
   logic [35:0] m_r = '0;
   logic [47:0] p_r = '0;
   logic [47:0] x_mux, z_mux;

   assign x_mux = (bus.OPMODE[1:0] == 2'b01) ? {12'b0, m_r} : 48'b0;
   assign z_mux = (bus.OPMODE[3:2] == 2'b10) ? p_r : 48'b0;

   always @(posedge CLK) begin
      if (bus.CE_PIPE) begin
         a_r <= a_in;
         b_r <= b_in;
         m_r <= a_r * b_r;
         p_r <= x_mux + z_mux;
      end
   end

   typedef struct {
      logic [63:0] exp_p;
      int          exp_ce;
      logic [63:0] exp_ops;
      int          exp_lat;
      int          exp_acc;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec    = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: traces each accepted run and scores it when done fires.
   initial begin
      int          cyc;
      int          ce_cnt;
      int          acc_cnt;
      logic [63:0] ops;
      bit          active;
      exp_t        e;
      active = 1'b0;
      cyc = 0; ce_cnt = 0; acc_cnt = 0; ops = '0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            active = 1'b0;
         end else begin
            if (active) begin
               cyc++;
               if (bus.CE_PIPE) begin
                  ce_cnt++;
                  ops = {ops[55:0], bus.OPMODE};
               end
               if (bus.in_valid && bus.in_ready) acc_cnt++;
            end
            if (bus.done) begin
               done_cnt++;
               if (sb_q.size() == 0) begin
                  check("unexpected_done", {63'b0, bus.done}, 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("p_final",  {16'b0, p_r},   e.exp_p);
                  check("ce_count", 64'(ce_cnt),    64'(e.exp_ce));
                  check("opmodes",  ops,            e.exp_ops);
                  check("latency",  64'(cyc),       64'(e.exp_lat));
                  check("accepts",  64'(acc_cnt),   64'(e.exp_acc));
                  check("busy_at_done", {63'b0, bus.busy}, 64'd1);
               end
               active = 1'b0;
            end
            if (bus.start && !bus.busy && !active) begin
               active = 1'b1;
               cyc = 0; ce_cnt = 0; acc_cnt = 0; ops = '0;
            end
         end
      end
   end

   task automatic run(input int n, input int nsend, input int av[4], input int bv[4],
                      input int gap_after, input int gap_len, input int pulse_idx,
                      input bit expect_done, input logic [63:0] ep, input int ece,
                      input logic [63:0] eops, input int elat);
      exp_t e;
      bit   got;
      if (expect_done) begin
         e.exp_p = ep; e.exp_ce = ece; e.exp_ops = eops; e.exp_lat = elat; e.exp_acc = n;
         sb_q.push_back(e);
      end
      @(posedge CLK); #1;
      bus.start     = 1'b1;
      bus.n_samples = CNT_W'(n);
      @(posedge CLK); #1;
      bus.start     = 1'b0;
      bus.n_samples = '1;
      for (int k = 0; k < nsend; k++) begin
         bus.in_valid = 1'b1;
         a_in = 18'(av[k]);
         b_in = 18'(bv[k]);
         if (k == pulse_idx) begin
            bus.start     = 1'b1;
            bus.n_samples = CNT_W'(5);
         end
         got = 1'b0;
         for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) check("in_ready_timeout", {63'b0, bus.in_ready}, 64'd1);
         @(posedge CLK); #1;
         bus.in_valid = 1'b0;
         bus.start    = 1'b0;
         a_in = 18'($urandom);
         b_in = 18'($urandom);
         if (k == gap_after) begin
            repeat (gap_len) @(posedge CLK);
            #1;
         end
      end
      if (expect_done) begin
         for (int t = 0; t < 100; t++) begin
            if (sb_q.size() == 0) break;
            @(negedge CLK);
         end
         if (sb_q.size() != 0) begin
            check("done_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
         end
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.n_samples = '0;
      bus.in_valid  = 1'b0;
      RST_N         = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy",     {63'b0, bus.busy},     64'd0);
      check("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
      check("rst_ce",       {63'b0, bus.CE_PIPE},  64'd0);
      check("rst_done",     {63'b0, bus.done},     64'd0);
      check("rst_opmode",   {56'b0, bus.OPMODE},   64'h08);
      RST_N = 1'b1;

      // 1: three samples, no stall: 6+20+42
      run(3, 3, '{2, 4, 6, 0}, '{3, 5, 7, 0}, -1, 0, -1, 1'b1,
          64'd68, 5, 64'h08_0801_0909, 6);
      // 2: two-cycle valid gap after the first sample
      run(3, 3, '{2, 4, 6, 0}, '{3, 5, 7, 0}, 0, 2, -1, 1'b1,
          64'd68, 5, 64'h08_0801_0909, 8);
      // 3: empty run leaves P alone
      run(0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, -1, 0, -1, 1'b1,
          64'd68, 0, 64'h0, 1);
      // 4: single-sample runs overwrite P
      run(1, 1, '{7, 0, 0, 0}, '{9, 0, 0, 0}, -1, 0, -1, 1'b1,
          64'd63, 3, 64'h08_0801, 4);
      run(1, 1, '{1, 0, 0, 0}, '{1, 0, 0, 0}, -1, 0, -1, 1'b1,
          64'd1, 3, 64'h08_0801, 4);
      // 5: start with n=5 during ACCUM is ignored
      run(3, 3, '{2, 4, 6, 0}, '{3, 5, 7, 0}, -1, 0, 1, 1'b1,
          64'd68, 5, 64'h08_0801_0909, 6);
      // 6: reset after two accepts, then a fresh n=2 run: 12+30
      run(3, 2, '{9, 9, 9, 0}, '{9, 9, 9, 0}, -1, 0, -1, 1'b0,
          64'd0, 0, 64'h0, 0);
      RST_N = 1'b0;
      #1;
      check("arst_busy",     {63'b0, bus.busy},     64'd0);
      check("arst_in_ready", {63'b0, bus.in_ready}, 64'd0);
      check("arst_ce",       {63'b0, bus.CE_PIPE},  64'd0);
      check("arst_opmode",   {56'b0, bus.OPMODE},   64'h08);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      run(2, 2, '{3, 5, 0, 0}, '{4, 6, 0, 0}, -1, 0, -1, 1'b1,
          64'd42, 4, 64'h0808_0109, 5);

      repeat (6) @(negedge CLK);
      check("done_pulses", 64'(done_cnt), 64'd7);
      check("sb_empty",    64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d done pulses", done_cnt);
      $fatal(1);
   end

endmodule
